// File: rtl/fft_dif_butterfly_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : fft_dif_butterfly_pipe_if
//  Purpose  : Operand/result bus with valid/ready handshakes for the
//             pipelined DIF butterfly.
//  Ports    : in_valid/in_ready + x, y, w operands (source -> butterfly)
//             out_valid/out_ready + a, b results  (butterfly -> sink)
//             All data signals are signed Q16.16, 32 bits.
//  Revision : 1.0  initial release
// ============================================================================
interface fft_dif_butterfly_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] xr;
    logic [31:0] xi;
    logic [31:0] yr;
    logic [31:0] yi;
    logic [31:0] wr;
    logic [31:0] wi;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ar;
    logic [31:0] ai;
    logic [31:0] br;
    logic [31:0] bi;

    // Butterfly side
    modport slave (
        input  in_valid, xr, xi, yr, yi, wr, wi, out_ready,
        output in_ready, out_valid, ar, ai, br, bi
    );

    // Source/sink side
    modport master (
        output in_valid, xr, xi, yr, yi, wr, wi, out_ready,
        input  in_ready, out_valid, ar, ai, br, bi
    );
endinterface
`default_nettype wire

// File: rtl/fft_dif_butterfly_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : fft_dif_butterfly_pipe
//  Purpose  : 3-stage pipelined radix-2 DIF butterfly
//                 a = x + y,  b = (x - y) * w
//             on signed Q16.16 complex samples, with optional conjugate
//             twiddle (INVERSE) and optional 1/2 output scaling (SCALE).
//  Ports    : clk  - clock, rising edge
//             rst  - synchronous active-high reset
//             bus  - fft_dif_butterfly_pipe_if.slave (operands, results,
//                    valid/ready on both sides)
//  Revision : 1.0  initial release
// ============================================================================
module fft_dif_butterfly_pipe #(
    parameter bit INVERSE = 1'b1,
    parameter bit SCALE   = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    fft_dif_butterfly_pipe_if.slave      bus
);

    // The product is Q32.32 after the multiply; the extra shift implements
    // the optional halving in the same arithmetic shift.
    localparam int unsigned c_SH = 16 + int'(SCALE);

    // ------------------------------------------------------------------
    // Flow control: each stage loads when empty or when the stage after it
    // is loading. in_ready is forced low during reset.
    // ------------------------------------------------------------------
    logic r_v1, r_v2, r_v3;
    logic w_ld1, w_ld2, w_ld3;
    logic w_in_fire;

    assign w_ld3     = !r_v3 || bus.out_ready;
    assign w_ld2     = !r_v2 || w_ld3;
    assign w_ld1     = !r_v1 || w_ld2;
    assign w_in_fire = bus.in_valid && w_ld1 && !rst;

    assign bus.in_ready  = w_ld1 && !rst;
    assign bus.out_valid = r_v3;

    // ------------------------------------------------------------------
    // S1: sums, differences (33-bit), twiddle with optional conjugate
    // ------------------------------------------------------------------
    logic signed [32:0] w_sr, w_si, w_dr, w_di;
    logic        [31:0] w_wi_eff;

    assign w_sr = {bus.xr[31], bus.xr} + {bus.yr[31], bus.yr};
    assign w_si = {bus.xi[31], bus.xi} + {bus.yi[31], bus.yi};
    assign w_dr = {bus.xr[31], bus.xr} - {bus.yr[31], bus.yr};
    assign w_di = {bus.xi[31], bus.xi} - {bus.yi[31], bus.yi};
    // 32-bit wrap: negating -2^31 yields -2^31.
    assign w_wi_eff = INVERSE ? (32'd0 - bus.wi) : bus.wi;

    logic signed [32:0] r_sr1, r_si1, r_dr1, r_di1;
    logic        [31:0] r_wr1, r_wi1;

    // ------------------------------------------------------------------
    // S2: four 33x32 signed products, held in 65 bits. Operands are
    // sign-extended to 65 bits so the low 65 bits of the product are the
    // exact signed result.
    // ------------------------------------------------------------------
    logic [64:0] w_dr_x, w_di_x, w_wr_x, w_wi_x;

    assign w_dr_x = {{32{r_dr1[32]}}, r_dr1};
    assign w_di_x = {{32{r_di1[32]}}, r_di1};
    assign w_wr_x = {{33{r_wr1[31]}}, r_wr1};
    assign w_wi_x = {{33{r_wi1[31]}}, r_wi1};

    logic signed [32:0] r_sr2, r_si2;
    logic        [64:0] r_p_rr, r_p_ii, r_p_ri, r_p_ir;

    // ------------------------------------------------------------------
    // S3: combine products at 66 bits, shift, keep low 32 bits (wrap)
    // ------------------------------------------------------------------
    logic signed [65:0] w_pr, w_pi, w_pr_sh, w_pi_sh;
    logic signed [32:0] w_sr_sh, w_si_sh;

    assign w_pr    = $signed({r_p_rr[64], r_p_rr}) - $signed({r_p_ii[64], r_p_ii});
    assign w_pi    = $signed({r_p_ri[64], r_p_ri}) + $signed({r_p_ir[64], r_p_ir});
    assign w_pr_sh = w_pr >>> c_SH;
    assign w_pi_sh = w_pi >>> c_SH;
    assign w_sr_sh = r_sr2 >>> SCALE;
    assign w_si_sh = r_si2 >>> SCALE;

    // Upper bits are discarded by design (wrap-around on overflow).
    logic w_unused;
    assign w_unused = ^{w_pr_sh[65:32], w_pi_sh[65:32], w_sr_sh[32], w_si_sh[32]};

    logic [31:0] r_ar, r_ai, r_br, r_bi;

    assign bus.ar = r_ar;
    assign bus.ai = r_ai;
    assign bus.br = r_br;
    assign bus.bi = r_bi;

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_v3   <= 1'b0;
            r_sr1  <= '0;
            r_si1  <= '0;
            r_dr1  <= '0;
            r_di1  <= '0;
            r_wr1  <= '0;
            r_wi1  <= '0;
            r_sr2  <= '0;
            r_si2  <= '0;
            r_p_rr <= '0;
            r_p_ii <= '0;
            r_p_ri <= '0;
            r_p_ir <= '0;
            r_ar   <= '0;
            r_ai   <= '0;
            r_br   <= '0;
            r_bi   <= '0;
        end else begin
            // S1
            if (w_ld1) begin
                r_v1 <= w_in_fire;
            end
            if (w_in_fire) begin
                r_sr1 <= w_sr;
                r_si1 <= w_si;
                r_dr1 <= w_dr;
                r_di1 <= w_di;
                r_wr1 <= bus.wr;
                r_wi1 <= w_wi_eff;
            end

            // S2
            if (w_ld2) begin
                r_v2 <= r_v1;
            end
            if (w_ld2 && r_v1) begin
                r_sr2  <= r_sr1;
                r_si2  <= r_si1;
                r_p_rr <= w_dr_x * w_wr_x;
                r_p_ii <= w_di_x * w_wi_x;
                r_p_ri <= w_dr_x * w_wi_x;
                r_p_ir <= w_di_x * w_wr_x;
            end

            // S3: holds its contents while out_valid && !out_ready
            if (w_ld3) begin
                r_v3 <= r_v2;
            end
            if (w_ld3 && r_v2) begin
                r_ar <= w_sr_sh[31:0];
                r_ai <= w_si_sh[31:0];
                r_br <= w_pr_sh[31:0];
                r_bi <= w_pi_sh[31:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_dif_butterfly_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_dif_butterfly_pipe
//  Purpose  : Directed self-checking bench for fft_dif_butterfly_pipe.
//             Three instances share the same stimulus:
//               u00 : SCALE=0 INVERSE=0
//               u01 : SCALE=0 INVERSE=1
//               u10 : SCALE=1 INVERSE=0
//             Inputs change on the falling edge; outputs are sampled 1 ns
//             after the falling edge, i.e. well away from the rising edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fft_dif_butterfly_pipe;

    logic clk;
    logic rst;

    fft_dif_butterfly_pipe_if if00 ();
    fft_dif_butterfly_pipe_if if01 ();
    fft_dif_butterfly_pipe_if if10 ();

    fft_dif_butterfly_pipe #(.INVERSE(1'b0), .SCALE(1'b0)) u00 (.clk(clk), .rst(rst), .bus(if00));
    fft_dif_butterfly_pipe #(.INVERSE(1'b1), .SCALE(1'b0)) u01 (.clk(clk), .rst(rst), .bus(if01));
    fft_dif_butterfly_pipe #(.INVERSE(1'b0), .SCALE(1'b1)) u10 (.clk(clk), .rst(rst), .bus(if10));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v,
                          input logic [31:0] xr, input logic [31:0] xi,
                          input logic [31:0] yr, input logic [31:0] yi,
                          input logic [31:0] wr, input logic [31:0] wi);
        if00.in_valid = v; if01.in_valid = v; if10.in_valid = v;
        if00.xr = xr; if01.xr = xr; if10.xr = xr;
        if00.xi = xi; if01.xi = xi; if10.xi = xi;
        if00.yr = yr; if01.yr = yr; if10.yr = yr;
        if00.yi = yi; if01.yi = yi; if10.yi = yi;
        if00.wr = wr; if01.wr = wr; if10.wr = wr;
        if00.wi = wi; if01.wi = wi; if10.wi = wi;
    endtask

    task automatic set_or(input logic r);
        if00.out_ready = r; if01.out_ready = r; if10.out_ready = r;
    endtask

    // Sends one operand set into an empty pipeline with out_ready high,
    // checks the 3-cycle latency, and leaves outputs visible for checking
    // (sampled in the cycle in which out_valid first rises).
    task automatic run_vec(input string tag,
                           input logic [31:0] xr, input logic [31:0] xi,
                           input logic [31:0] yr, input logic [31:0] yi,
                           input logic [31:0] wr, input logic [31:0] wi);
        @(negedge clk);
        set_or(1'b1);
        set_in(1'b1, xr, xi, yr, yi, wr, wi);
        #1;
        check_eq({tag, "_in_ready"}, 32'(if00.in_ready), 32'd1);
        @(negedge clk);                 // cycle c+1
        set_in(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        #1;
        check_eq({tag, "_early_valid"}, 32'(if00.out_valid), 32'd0);
        @(negedge clk);                 // cycle c+2
        #1;
        check_eq({tag, "_early_valid2"}, 32'(if00.out_valid), 32'd0);
        @(negedge clk);                 // cycle c+3
        #1;
        check_eq({tag, "_out_valid"}, 32'(if00.out_valid), 32'd1);
    endtask

    int k, acc, got, last_c;
    int n_out_after_rst;
    logic fire_in, fire_out;

    initial begin
        rst = 1'b1;
        set_or(1'b1);
        set_in(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_out_valid", 32'(if00.out_valid), 32'd0);
        check_eq("rst_in_ready",  32'(if00.in_ready),  32'd0);
        check_eq("rst_ar",        if00.ar, 32'd0);
        check_eq("rst_bi",        if00.bi, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_in_ready", 32'(if00.in_ready), 32'd1);

        // Basic and scaling: x=(1.0,0), y=(0.5,0), w=(1.0,0)
        run_vec("basic", 32'h0001_0000, 32'd0, 32'h0000_8000, 32'd0, 32'h0001_0000, 32'd0);
        check_eq("basic_ar",  if00.ar, 32'h0001_8000);
        check_eq("basic_ai",  if00.ai, 32'h0000_0000);
        check_eq("basic_br",  if00.br, 32'h0000_8000);
        check_eq("basic_bi",  if00.bi, 32'h0000_0000);
        check_eq("scale_ar",  if10.ar, 32'h0000_C000);
        check_eq("scale_ai",  if10.ai, 32'h0000_0000);
        check_eq("scale_br",  if10.br, 32'h0000_4000);
        check_eq("scale_bi",  if10.bi, 32'h0000_0000);

        // Conjugate twiddle: w=(0,1.0)
        run_vec("conj", 32'h0001_0000, 32'd0, 32'h0000_8000, 32'd0, 32'd0, 32'h0001_0000);
        check_eq("conj_inv1_br", if01.br, 32'h0000_0000);
        check_eq("conj_inv1_bi", if01.bi, 32'hFFFF_8000);
        check_eq("conj_inv0_br", if00.br, 32'h0000_0000);
        check_eq("conj_inv0_bi", if00.bi, 32'h0000_8000);

        // Truncation toward -inf: (1 * 0.5) -> 0, (-1 * 0.5) -> -1 LSB
        run_vec("trunc_pos", 32'h0000_0001, 32'd0, 32'd0, 32'd0, 32'h0000_8000, 32'd0);
        check_eq("trunc_pos_br", if00.br, 32'h0000_0000);
        check_eq("trunc_pos_ar", if00.ar, 32'h0000_0001);
        run_vec("trunc_neg", 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'h0000_8000, 32'd0);
        check_eq("trunc_neg_br", if00.br, 32'hFFFF_FFFF);
        check_eq("trunc_neg_ar", if00.ar, 32'hFFFF_FFFF);

        // Drain
        @(negedge clk);
        set_or(1'b1);
        repeat (3) @(negedge clk);

        // Backpressure: set k is x=(k<<16, k), y=0, w=(1.0,0)
        // expected on u00: ar=k<<16, ai=k, br=k<<16, bi=k
        k = 1; acc = 0; got = 0; last_c = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            set_or(c >= 6);
            if (k <= 5)
                set_in(1'b1, 32'(k) << 16, 32'(k), 32'd0, 32'd0, 32'h0001_0000, 32'd0);
            else
                set_in(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
            #1;
            if (c == 5) begin
                check_eq("bp_accepted",  32'(acc), 32'd3);
                check_eq("bp_in_ready",  32'(if00.in_ready), 32'd0);
                check_eq("bp_hold_valid", 32'(if00.out_valid), 32'd1);
                check_eq("bp_hold_ar",   if00.ar, 32'h0001_0000);
                check_eq("bp_hold_bi",   if00.bi, 32'h0000_0001);
            end
            fire_in  = if00.in_valid && if00.in_ready;
            fire_out = if00.out_valid && if00.out_ready;
            if (fire_out) begin
                got++;
                check_eq("bp_ar", if00.ar, 32'(got) << 16);
                check_eq("bp_ai", if00.ai, 32'(got));
                check_eq("bp_br", if00.br, 32'(got) << 16);
                check_eq("bp_bi", if00.bi, 32'(got));
                if (got > 1) check_eq("bp_rate", 32'(c - last_c), 32'd1);
                last_c = c;
            end
            @(posedge clk);
            if (fire_in) begin
                k++;
                acc++;
            end
            if (got == 5) break;
        end
        check_eq("bp_count", 32'(got), 32'd5);
        @(negedge clk);
        #1;
        check_eq("bp_no_dup", 32'(if00.out_valid), 32'd0);

        // Reset mid-stream with two sets in flight
        @(negedge clk);
        set_in(1'b1, 32'h0003_0000, 32'd0, 32'd0, 32'd0, 32'h0001_0000, 32'd0);
        @(negedge clk);
        set_in(1'b1, 32'h0004_0000, 32'd0, 32'd0, 32'd0, 32'h0001_0000, 32'd0);
        @(negedge clk);
        set_in(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_in_ready", 32'(if00.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        set_in(1'b1, 32'h0007_0000, 32'd0, 32'd0, 32'd0, 32'h0001_0000, 32'd0);
        #1;
        check_eq("mid_rst_out_valid", 32'(if00.out_valid), 32'd0);
        check_eq("mid_rst_ar",        if00.ar, 32'd0);
        check_eq("mid_rst_br",        if00.br, 32'd0);
        check_eq("mid_rst_in_ready2", 32'(if00.in_ready), 32'd1);
        n_out_after_rst = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            set_in(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
            #1;
            if (if00.out_valid) begin
                n_out_after_rst++;
                check_eq("mid_rst_new_cycle", 32'(c), 32'd2);
                check_eq("mid_rst_new_ar", if00.ar, 32'h0007_0000);
                check_eq("mid_rst_new_br", if00.br, 32'h0007_0000);
            end
        end
        check_eq("mid_rst_out_count", 32'(n_out_after_rst), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_dif_butterfly_pipe.md
Name: fft_dif_butterfly_pipe

Overview:
- Pipelined radix-2 decimation-in-frequency butterfly: a = x + y, b = (x − y)·w.
- Complex signed 32-bit Q16.16 samples, same format as the combinational DIT butterfly.
- Used as the inverse-path (IFFT) and DIF stage engine in the FFT datapath.
- Adds valid/ready flow control, optional conjugate twiddle and optional per-stage 1/2 scaling, so an N-point IFFT can apply 1/N across log2(N) stages.

Parameters:
- INVERSE, 1: 1 = use conj(w), i.e. (wr, −wi); 0 = use w as given.
- SCALE, 1: 1 = divide both outputs by 2 (arithmetic shift); 0 = no scaling.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input operand set is valid.
- in_ready  out  1  block can accept an operand set this cycle.
- xr, xi, yr, yi  in  32 each  signed Q16.16 operands x, y.
- wr, wi  in  32 each  signed Q16.16 twiddle.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- ar, ai, br, bi  out  32 each  signed Q16.16 results.

Behaviour:
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - While out_valid && !out_ready, ar/ai/br/bi and out_valid are held stable.
- Pipeline:
  - 3 register stages S1, S2, S3, each with its own valid bit. S3 drives the outputs.
  - Stage k loads when its valid is 0 or stage k+1 loads (S3 loads when !out_valid || out_ready).
  - in_ready = S1 load enable, combinational from out_ready; no skid buffer.
  - Latency is 3 cycles from input transfer to out_valid with out_ready held high.
  - Throughput is 1 result per cycle; bubbles collapse.
- S1:
  - sr = xr + yr and si = xi + yi, 33-bit signed.
  - dr = xr − yr and di = xi − yi, 33-bit signed.
  - Register wr and the effective wi (negated when INVERSE = 1; negation wraps 32-bit, so −(−2^31) = −2^31).
- S2:
  - Four signed 33×32 products: dr·wr, di·wi', dr·wi', di·wr (65-bit).
  - Carry sr and si forward.
- S3:
  - pr = dr·wr − di·wi' and pi = dr·wi' + di·wr, computed at ≥66 bits.
  - br = (pr >>> (16+SCALE))[31:0] and bi = (pi >>> (16+SCALE))[31:0].
  - ar = (sr >>> SCALE)[31:0] and ai = (si >>> SCALE)[31:0].
- Rounding is truncation toward −∞ (arithmetic shift). Overflow wraps (low 32 bits kept); no saturation.
- Reset:
  - While rst = 1 at a clock edge: all stage valids clear, out_valid = 0, and ar/ai/br/bi plus all pipeline data registers = 0.
  - in_ready = 0 while rst is high; it is 1 in the first cycle after rst deasserts.
  - Reset mid-operation discards all in-flight operands; there is no partial output.
- Simultaneous events:
  - With a full pipeline, out_ready = 1 and in_valid = 1, one result leaves and one operand enters in the same cycle.
  - in_valid with in_ready = 0: no transfer; the source must hold its data.
- Data outputs while out_valid = 0 are don't-care to the consumer, but must not change while out_valid = 1 and out_ready = 0.

Test Plan:
- Basic, SCALE = 0, INVERSE = 0:
  - Stimulus: x = (0x00010000, 0), y = (0x00008000, 0), w = (0x00010000, 0), out_ready = 1.
  - Required: 3 cycles later out_valid = 1, ar = 0x00018000, ai = 0, br = 0x00008000, bi = 0.
- Scaling, SCALE = 1, same stimulus:
  - Required: ar = 0x0000C000, br = 0x00004000, ai = bi = 0.
- Conjugate twiddle, SCALE = 0:
  - Stimulus: same x, y; w = (0, 0x00010000).
  - Required with INVERSE = 1: br = 0, bi = 0xFFFF8000.
  - Required with INVERSE = 0: bi = 0x00008000.
- Truncation, SCALE = 0, INVERSE = 0:
  - Stimulus: x = (0x00000001, 0), y = 0, w = (0x00008000, 0).
  - Required: br = 0.
  - Stimulus: xr = 0xFFFFFFFF, same y and w.
  - Required: br = 0xFFFFFFFF.
- Backpressure:
  - Stimulus: out_ready = 0, in_valid held high with 5 distinct operand sets.
  - Required: exactly 3 accepted, then in_ready = 0 and outputs stable.
  - Then out_ready = 1: all 5 results emerge in order, with no loss and no duplicates, at 1 per cycle.
- Reset mid-stream:
  - Stimulus: assert rst for 1 cycle with 2 operand sets in flight.
  - Required: next cycle out_valid = 0 and outputs = 0; no stale result appears afterwards; first new input is accepted the cycle after rst deasserts.
